// File: rtl/updown_counter_gen.sv
// Up/down event/credit counter with run-time limits, programmable step,
// saturate-or-wrap mode, sticky overflow/underflow flags and a terminal-count pulse.
module updown_counter_gen #(
  parameter int W  = 8,
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          load,
  input  logic [W-1:0]  din,
  input  logic          inc,
  input  logic          dec,
  input  logic [SW-1:0] step,
  input  logic [W-1:0]  lo_lim,
  input  logic [W-1:0]  hi_lim,
  input  logic          wrap_mode,
  input  logic          clr_flags,
  output logic [W-1:0]  count,
  output logic          at_max,
  output logic          at_min,
  output logic          ovf_sticky,
  output logic          udf_sticky,
  output logic          tc_pulse,
  output logic          cfg_err
);

  // Signed headroom wide enough for count +/- step and the wrap correction,
  // so no intermediate result can silently wrap.
  localparam int AW = ((W > SW) ? W : SW) + 2;

  logic signed [AW-1:0] cnt_x, step_x, lo_x, hi_x, range_x;
  logic signed [AW-1:0] sum_x, diff_x, wrap_up_x, wrap_dn_x;
  logic [W-1:0]         count_next;
  logic                 ovf_set, udf_set, do_count, step_bad;

  assign cnt_x     = $signed({{(AW-W){1'b0}}, count});
  assign step_x    = $signed({{(AW-SW){1'b0}}, step});
  assign lo_x      = $signed({{(AW-W){1'b0}}, lo_lim});
  assign hi_x      = $signed({{(AW-W){1'b0}}, hi_lim});
  assign range_x   = hi_x - lo_x + 1;
  assign sum_x     = cnt_x + step_x;
  assign diff_x    = cnt_x - step_x;
  assign wrap_up_x = sum_x - range_x;
  assign wrap_dn_x = diff_x + range_x;
  assign step_bad  = step_x > range_x;

  assign cfg_err = hi_lim < lo_lim;
  assign at_max  = count == hi_lim;
  assign at_min  = count == lo_lim;

  always_comb begin
    count_next = count;
    ovf_set    = 1'b0;
    udf_set    = 1'b0;
    do_count   = 1'b0;
    if (!cfg_err) begin
      if (load) begin
        if (din < lo_lim)      count_next = lo_lim;
        else if (din > hi_lim) count_next = hi_lim;
        else                   count_next = din;
      end else if (en && (inc ^ dec) && (step != '0)) begin
        do_count = 1'b1;
        if (inc) begin
          if (sum_x > hi_x) begin
            ovf_set = 1'b1;
            // Wrapped results that still land outside the window (oversized step,
            // or count stranded by a limit change) fall back to the crossed limit.
            if (wrap_mode && !step_bad && wrap_up_x >= lo_x && wrap_up_x <= hi_x)
              count_next = wrap_up_x[W-1:0];
            else
              count_next = hi_lim;
          end else if (sum_x < lo_x) begin
            count_next = lo_lim;
          end else begin
            count_next = sum_x[W-1:0];
          end
        end else begin
          if (diff_x < lo_x) begin
            udf_set = 1'b1;
            if (wrap_mode && !step_bad && wrap_dn_x >= lo_x && wrap_dn_x <= hi_x)
              count_next = wrap_dn_x[W-1:0];
            else
              count_next = lo_lim;
          end else if (diff_x > hi_x) begin
            count_next = hi_lim;
          end else begin
            count_next = diff_x[W-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count      <= '0;
      ovf_sticky <= 1'b0;
      udf_sticky <= 1'b0;
      tc_pulse   <= 1'b0;
    end else begin
      count    <= count_next;
      tc_pulse <= ovf_set | udf_set;
      if (!cfg_err) begin
        // A new crossing wins over a same-cycle clear.
        if (ovf_set)        ovf_sticky <= 1'b1;
        else if (clr_flags) ovf_sticky <= 1'b0;
        if (udf_set)        udf_sticky <= 1'b1;
        else if (clr_flags) udf_sticky <= 1'b0;
      end
    end
  end

`ifndef SYNTHESIS
  a_ctrl_known: assert property (@(posedge clk) !$isunknown({reset_n, load, inc, dec, en}));
  a_din_known: assert property (@(posedge clk) disable iff (!reset_n) load |-> !$isunknown(din));
  a_wrap_step: assert property (@(posedge clk) disable iff (!reset_n)
    (do_count && wrap_mode) |-> (step_x <= range_x));
  a_in_range: assert property (@(posedge clk) disable iff (!reset_n)
    do_count |=> (count >= $past(lo_lim) && count <= $past(hi_lim)));
`endif

endmodule

// File: tb/tb_updown_counter_gen.sv
// Directed bench for updown_counter_gen: the driver queues hand-computed
// expectations tagged with a cycle number, a negedge monitor pops and compares.
module tb_updown_counter_gen;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b1, load = 1'b0, inc = 1'b0, dec = 1'b0;
  logic       wrap_mode = 1'b0, clr_flags = 1'b0;
  logic [7:0] din = 8'd0, lo_lim = 8'd0, hi_lim = 8'd40;
  logic [3:0] step = 4'd0;
  logic [7:0] count;
  logic       at_max, at_min, ovf_sticky, udf_sticky, tc_pulse, cfg_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    string      name;
    logic [7:0] cnt;
    logic       ovf, udf, tc, amax, amin, cerr;
  } exp_t;
  exp_t sbq[$];

  updown_counter_gen #(.W(8), .SW(4)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .load(load), .din(din),
    .inc(inc), .dec(dec), .step(step), .lo_lim(lo_lim), .hi_lim(hi_lim),
    .wrap_mode(wrap_mode), .clr_flags(clr_flags), .count(count),
    .at_max(at_max), .at_min(at_min), .ovf_sticky(ovf_sticky),
    .udf_sticky(udf_sticky), .tc_pulse(tc_pulse), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input string field, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %0s.%0s got %0d expected %0d", name, field, act, expv);
    end
  endtask

  // Monitor: compares every expectation due by the current cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      chk(e.name, "count", int'(count), int'(e.cnt));
      chk(e.name, "ovf", int'(ovf_sticky), int'(e.ovf));
      chk(e.name, "udf", int'(udf_sticky), int'(e.udf));
      chk(e.name, "tc", int'(tc_pulse), int'(e.tc));
      chk(e.name, "at_max", int'(at_max), int'(e.amax));
      chk(e.name, "at_min", int'(at_min), int'(e.amin));
      chk(e.name, "cfg_err", int'(cfg_err), int'(e.cerr));
      $display("cyc=%0d %0s count=%0d ovf=%0b udf=%0b tc=%0b cfg=%0b",
               cyc, e.name, count, ovf_sticky, udf_sticky, tc_pulse, cfg_err);
    end
  end

  // Expected state 'off' clock edges from now; flag decodes follow the current limits.
  task automatic expect_st(input string name, input int off, input logic [7:0] c,
                           input logic o, input logic u, input logic t);
    exp_t e;
    e.cyc  = cyc + off;
    e.name = name;
    e.cnt  = c;
    e.ovf  = o;
    e.udf  = u;
    e.tc   = t;
    e.amax = (c == hi_lim);
    e.amin = (c == lo_lim);
    e.cerr = (hi_lim < lo_lim);
    sbq.push_back(e);
  endtask

  task automatic go(input logic ld, input logic [7:0] d, input logic i, input logic dc,
                    input logic [3:0] s, input logic e, input logic c);
    @(negedge clk);
    #1;
    load = ld; din = d; inc = i; dec = dc; step = s; en = e; clr_flags = c;
  endtask

  task automatic lim(input logic [7:0] lo, input logic [7:0] hi, input logic wm);
    lo_lim = lo; hi_lim = hi; wrap_mode = wm;
  endtask

  initial begin
    // Reset held, then released
    go(0, 0, 0, 0, 0, 1, 0); expect_st("rst_hold", 1, 0, 0, 0, 0);
    reset_n = 1'b1;
    // Async reset mid-count
    go(1, 37, 0, 0, 0, 1, 0); expect_st("load37", 1, 37, 0, 0, 0);
    go(0, 0, 1, 0, 5, 1, 0);  expect_st("ovf_sat40", 1, 40, 1, 0, 1);
    go(1, 37, 0, 0, 0, 1, 0); expect_st("reload37", 1, 37, 1, 0, 0);
    go(0, 0, 0, 0, 0, 1, 0);
    @(posedge clk); #2;
    reset_n = 1'b0;
    expect_st("async_rst", 0, 0, 0, 0, 0);
    go(0, 0, 0, 0, 0, 1, 0); reset_n = 1'b1;
    // Saturating overflow
    go(1, 18, 0, 0, 0, 1, 0); lim(10, 20, 0); expect_st("sat_load18", 1, 18, 0, 0, 0);
    go(0, 0, 1, 0, 5, 1, 0);  expect_st("sat_ovf", 1, 20, 1, 0, 1);
    go(0, 0, 0, 0, 0, 1, 0);  expect_st("tc_drop", 1, 20, 1, 0, 0);
    go(0, 0, 0, 0, 0, 1, 1);  expect_st("clr1", 1, 20, 0, 0, 0);
    // Wrap mode
    go(1, 18, 0, 0, 0, 1, 0); lim(10, 20, 1); expect_st("wrap_load18", 1, 18, 0, 0, 0);
    go(0, 0, 1, 0, 5, 1, 0);  expect_st("wrap_ovf", 1, 12, 1, 0, 1);
    go(1, 11, 0, 0, 0, 1, 0); expect_st("wrap_load11", 1, 11, 1, 0, 0);
    go(0, 0, 0, 1, 3, 1, 0);  expect_st("wrap_udf", 1, 19, 1, 1, 1);
    go(0, 0, 1, 0, 1, 1, 0);  expect_st("inc_to_hi", 1, 20, 1, 1, 0);
    go(0, 0, 0, 1, 4, 1, 0);  expect_st("dec4", 1, 16, 1, 1, 0);
    go(0, 0, 1, 0, 0, 1, 0);  expect_st("step0", 1, 16, 1, 1, 0);
    // Load clamp, inc&dec together, en low
    go(0, 0, 0, 0, 0, 1, 1);  expect_st("clr2", 1, 16, 0, 0, 0);
    go(1, 250, 0, 0, 0, 1, 0); expect_st("load250", 1, 20, 0, 0, 0);
    go(0, 0, 1, 1, 3, 1, 0);  expect_st("inc_dec", 1, 20, 0, 0, 0);
    go(0, 0, 0, 1, 3, 0, 0);  expect_st("en_low", 1, 20, 0, 0, 0);
    // Set beats clear
    go(0, 0, 1, 0, 1, 1, 0); lim(10, 20, 0); expect_st("ovf_again", 1, 20, 1, 0, 1);
    go(0, 0, 1, 0, 1, 1, 1);  expect_st("set_vs_clr", 1, 20, 1, 0, 1);
    go(0, 0, 0, 0, 0, 1, 1);  expect_st("clr3", 1, 20, 0, 0, 0);
    // Saturating underflow and exact lower boundary
    go(1, 12, 0, 0, 0, 1, 0); expect_st("load12", 1, 12, 0, 0, 0);
    go(0, 0, 0, 1, 5, 1, 0);  expect_st("sat_udf", 1, 10, 0, 1, 1);
    go(1, 15, 0, 0, 0, 1, 0); expect_st("load15", 1, 15, 0, 1, 0);
    go(0, 0, 0, 1, 5, 1, 0);  expect_st("dec_to_lo", 1, 10, 0, 1, 0);
    go(0, 0, 0, 0, 0, 1, 1);  expect_st("clr4", 1, 10, 0, 0, 0);
    // Inverted limits: count frozen
    go(0, 0, 0, 0, 0, 1, 0); lim(30, 20, 0); expect_st("cfg_err", 1, 10, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      if (k % 2 == 0) go(0, 0, 1, 0, 5, 1, 0);
      else            go(1, 25, 0, 0, 0, 1, 0);
      expect_st($sformatf("cfg_hold%0d", k), 1, 10, 0, 0, 0);
    end
    go(0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 20 && sbq.size() > 0; k++) @(posedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
